// File: rtl/counter_145.sv
// Free-running parameterised sequence generator: y walks SEQ0..SEQ(SEQ_LEN-1) one entry per clock and wraps.
// y is held in its own register, loaded with the entry for the next index, so it never decodes combinationally.
module counter_145 #(
   parameter int unsigned SEQ_LEN = 32'd3,
   parameter int unsigned SEQ0    = 32'd1,
   parameter int unsigned SEQ1    = 32'd4,
   parameter int unsigned SEQ2    = 32'd5,
   parameter int unsigned SEQ3    = 32'd0,
   parameter int unsigned SEQ4    = 32'd0,
   parameter int unsigned SEQ5    = 32'd0,
   parameter int unsigned SEQ6    = 32'd0,
   parameter int unsigned SEQ7    = 32'd0
) (
   input  logic       clk,
   input  logic       reset,
   output logic [3:0] y
);

   if ((SEQ_LEN < 32'd1) || (SEQ_LEN > 32'd8)) begin : g_bad_len
      $error("counter_145: SEQ_LEN must lie in 1..8");
   end

   if ((SEQ0 > 32'd15) || (SEQ1 > 32'd15) || (SEQ2 > 32'd15) || (SEQ3 > 32'd15) ||
       (SEQ4 > 32'd15) || (SEQ5 > 32'd15) || (SEQ6 > 32'd15) || (SEQ7 > 32'd15)) begin : g_bad_val
      $error("counter_145: every sequence entry must fit in 4 bits");
   end

   localparam logic [2:0] LAST_IDX = 3'(SEQ_LEN - 32'd1);

   function automatic logic [3:0] seq_at(input logic [2:0] i);
      case (i)
         3'd0:    seq_at = SEQ0[3:0];
         3'd1:    seq_at = SEQ1[3:0];
         3'd2:    seq_at = SEQ2[3:0];
         3'd3:    seq_at = SEQ3[3:0];
         3'd4:    seq_at = SEQ4[3:0];
         3'd5:    seq_at = SEQ5[3:0];
         3'd6:    seq_at = SEQ6[3:0];
         3'd7:    seq_at = SEQ7[3:0];
         default: seq_at = SEQ0[3:0];
      endcase
   endfunction

   logic [2:0] idx_q, idx_d;
   logic [3:0] y_q, y_d;

   // Next index: an out-of-range or unknown index falls into the wrap branch and restarts at 0.
   always_comb begin
      idx_d = 3'd0;
      if (idx_q < LAST_IDX) begin
         idx_d = idx_q + 3'd1;
      end else begin
         idx_d = 3'd0;
      end
      y_d = seq_at(idx_d);
   end

   // Index and output registers with immediate reset to the first entry.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q <= 3'd0;
         y_q   <= SEQ0[3:0];
      end else begin
         idx_q <= idx_d;
         y_q   <= y_d;
      end
   end

   assign y = y_q;

endmodule

// File: tb/tb_counter_145.sv
// Randomised self-checking bench: three configurations of counter_145 compared against
// an index-modulo-length model of the sequence, with random asynchronous resets mixed in.
module tb_counter_145;

   logic       clk;
   logic       reset;
   logic [3:0] y_a, y_b, y_c;

   int n_tests = 0;
   int n_fail  = 0;
   int k       = 0;   // edges since the most recent reset release

   int seq_a[3] = '{1, 4, 5};
   int seq_b[5] = '{1, 4, 5, 9, 15};

   counter_145 dut (.clk(clk), .reset(reset), .y(y_a));

   counter_145 #(.SEQ_LEN(32'd5), .SEQ3(32'd9), .SEQ4(32'd15)) dut5 (
      .clk(clk), .reset(reset), .y(y_b));

   counter_145 #(.SEQ_LEN(32'd1)) dut1 (.clk(clk), .reset(reset), .y(y_c));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t, k=%0d)", tag, got, exp, $time, k);
      end
   endtask

   task automatic check_model(input string tag);
      check_val({tag, "_len3"}, y_a, 4'(seq_a[k % 3]));
      check_val({tag, "_len5"}, y_b, 4'(seq_b[k % 5]));
      check_val({tag, "_len1"}, y_c, 4'd1);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1;
      k++;
      check_model(tag);
   endtask

   task automatic check_in_reset(input string tag);
      check_val({tag, "_len3"}, y_a, 4'd1);
      check_val({tag, "_len5"}, y_b, 4'd1);
      check_val({tag, "_len1"}, y_c, 4'd1);
   endtask

   initial begin
      reset = 1'b0;
      #3;
      // Hold reset for 100 ns, checking on both clock edges.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_in_reset("rst_pos");
         @(negedge clk);
         check_in_reset("rst_neg");
      end

      reset = 1'b1;
      k = 0;
      for (int i = 0; i < 6; i++) step("seq");

      // Async reset between edges while y=5 on the length-3 instance.
      while ((k % 3) != 2) step("seek");
      @(negedge clk);
      #4;
      reset = 1'b0;
      #1;
      check_in_reset("async_rst");
      @(negedge clk);
      reset = 1'b1;
      k = 0;
      step("after_rst");

      // Illegal index on the length-3 instance, injected where the model wraps next anyway.
      while ((k % 3) != 2) step("seek2");
      @(negedge clk);
      force dut.idx_q = 3'd7;
      #2;
      release dut.idx_q;
      step("illegal1");
      step("illegal2");

      // Random run lengths interleaved with random mid-cycle resets.
      for (int it = 0; it < 25; it++) begin
         int run_len;
         int hold;
         run_len = int'($urandom_range(1, 40));
         for (int i = 0; i < run_len; i++) step("rand_run");
         if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            #($urandom_range(1, 7));
            reset = 1'b0;
            #1;
            check_in_reset("rand_rst");
            hold = int'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) begin
               @(posedge clk);
               #1;
               check_in_reset("rand_hold");
            end
            @(negedge clk);
            reset = 1'b1;
            k = 0;
         end
      end

      // Long free run.
      for (int i = 0; i < 3000; i++) step("long");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/counter_145.md
Name: counter_145

Overview:
- Free-running 4-bit sequence counter. Output y steps through a fixed, parameterised list of values, one step per clock, and wraps to the start.
- Default sequence: 1 → 4 → 5 → 1 → …
- Used as a small pattern/state generator. The block has no enable and no load inputs.

Parameters:
- SEQ_LEN, 3, number of active sequence entries; legal range 1..8.
- SEQ0, 4'd1, sequence entry 0; also the reset value of y.
- SEQ1, 4'd4, sequence entry 1.
- SEQ2, 4'd5, sequence entry 2.
- SEQ3..SEQ7, 4'd0, entries 3..7; used only when SEQ_LEN exceeds their index.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately.
- y  output  4  current sequence value; driven directly from a register.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on port reset.
- State:
  - 3-bit index register idx.
  - 4-bit output register y. y always equals SEQ[idx]; store it as a register, not decoded combinationally.
- While reset=0:
  - idx=0, y=SEQ0 (default 4'd1), regardless of clk.
  - Asserting reset mid-sequence takes effect immediately, without waiting for a clock edge.
- After reset goes to 1: on each rising clk edge,
  - if idx == SEQ_LEN-1, then idx_next = 0;
  - otherwise idx_next = idx+1;
  - y <= SEQ[idx_next].
- Latency:
  - The first rising edge after reset deassertion moves y to SEQ1 (default 4).
  - A deassertion coincident with a clock edge follows the standard async-reset flop behaviour; no synchroniser is included.
- Default cycle, period 3 clocks: 1, 4, 5, 1, 4, 5, …
- SEQ_LEN=1: y holds SEQ0 forever.
- Wrap-around: after the last active entry, the next value is always SEQ0; there is no dead cycle.
- Illegal-state recovery: if idx ≥ SEQ_LEN (e.g. upset or X), the next edge forces idx=0 and y=SEQ0.
- Elaboration-time checks: if SEQ_LEN is outside 1..8, or any SEQn does not fit 4 bits, report an error.
- y never glitches between edges; it changes only on a clk rising edge or on reset assertion.

Test Plan:
- Reset: hold reset=0 for 100 ns with clk toggling at a 20 ns period → y=1 throughout; no change on any clk edge.
- Sequence: release reset=1, then sample after each rising edge → y = 4, 5, 1, 4, 5, 1 over 6 edges.
- Async reset mid-sequence: assert reset=0 between edges while y=5 → y=1 immediately, before the next edge; release → next edge gives y=4.
- Parameter override: SEQ_LEN=5 with SEQ3=9, SEQ4=15 → y = 1, 4, 5, 9, 15, 1 …; SEQ_LEN=1 → y stays 1 across 10 edges.
- Illegal state: force idx=7 with the default SEQ_LEN=3, then release the force → after 1 edge y=1; after the next edge y=4.
- Long run: 3000 clocks with no reset → y is never outside {1, 4, 5}, and the period is exactly 3.
